// File: rtl/full_adder_pkg.sv
// full_adder_pkg
//   Shared definitions for the full_adder slice. The counter width, the
//   saturation value and the counter type are used by the optional
//   statistics counters (FULL_ADDER_STATS_EN).
package full_adder_pkg;

  localparam int          CNT_W   = 16;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage : full_adder_pkg

// File: rtl/full_adder_if.sv
// full_adder_if
//   Operand and result bundle for one full_adder cell.
//   Signals:
//     A, B, Cin   operand bits (driven by the master)
//     in_valid    qualifies A/B/Cin for capture into the registered path
//     Sum, Carry  combinational result (driven by the cell)
//     Sum_r       registered Sum
//     Carry_r     registered Carry
//     out_valid   one-cycle pulse: Sum_r/Carry_r hold a freshly captured result
//   Modports:
//     master  the side that supplies operands
//     slave   the adder cell
interface full_adder_if;

  logic A;
  logic B;
  logic Cin;
  logic in_valid;
  logic Sum;
  logic Carry;
  logic Sum_r;
  logic Carry_r;
  logic out_valid;

  modport master (
    output A, B, Cin, in_valid,
    input  Sum, Carry, Sum_r, Carry_r, out_valid
  );

  modport slave (
    input  A, B, Cin, in_valid,
    output Sum, Carry, Sum_r, Carry_r, out_valid
  );

endinterface : full_adder_if

// File: rtl/full_adder_half_adder.sv
// half_adder
//   Single-bit half adder, the building block of full_adder.
//   Ports:
//     a, b  input operand bits
//     s     sum,   a ^ b
//     c     carry, a & b
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// File: rtl/full_adder.sv
// full_adder
//   Single-bit full adder with a combinational result and a registered,
//   valid-qualified copy of that result (one-cycle stage for pipelined
//   ripple chains).
//   Ports:
//     clk        clock, all state updates on the rising edge
//     rst        synchronous, active-high reset
//     fa         full_adder_if.slave: A, B, Cin, in_valid in;
//                Sum, Carry, Sum_r, Carry_r, out_valid out
//   Optional (macro FULL_ADDER_STATS_EN defined):
//     carry_cnt  accepted inputs producing Carry = 1, saturating at 16'hFFFF
//     op_cnt     all accepted inputs, saturating at 16'hFFFF
module full_adder
  import full_adder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  full_adder_if.slave       fa
`ifdef FULL_ADDER_STATS_EN
  ,
  output cnt_t              carry_cnt,
  output cnt_t              op_cnt
`endif
);

  logic s0;
  logic c0;
  logic sum;
  logic c1;
  logic carry;

  // First stage adds A+B, second folds in Cin; at most one of the two
  // partial carries can be set, so OR-ing them gives the carry-out.
  half_adder u_ha0 (
    .a (fa.A),
    .b (fa.B),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (fa.Cin),
    .s (sum),
    .c (c1)
  );

  assign carry    = c0 | c1;
  assign fa.Sum   = sum;
  assign fa.Carry = carry;

  logic sum_q;
  logic carry_q;
  logic valid_q;

  // Results hold when idle; only out_valid drops back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (fa.in_valid) begin
      sum_q   <= sum;
      carry_q <= carry;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign fa.Sum_r     = sum_q;
  assign fa.Carry_r   = carry_q;
  assign fa.out_valid = valid_q;

`ifdef FULL_ADDER_STATS_EN
  cnt_t carry_cnt_q;
  cnt_t op_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt_q <= '0;
      op_cnt_q    <= '0;
    end else if (fa.in_valid) begin
      if (op_cnt_q != CNT_MAX)
        op_cnt_q <= op_cnt_q + cnt_t'(1);
      if (carry && (carry_cnt_q != CNT_MAX))
        carry_cnt_q <= carry_cnt_q + cnt_t'(1);
    end
  end

  assign carry_cnt = carry_cnt_q;
  assign op_cnt    = op_cnt_q;
`endif

endmodule : full_adder

// File: tb/tb_full_adder.sv
// tb_full_adder
//   Directed-vector bench for full_adder. Define FULL_ADDER_STATS_EN for
//   both RTL and bench to also exercise the statistics counters.
module tb_full_adder;

  logic clk;
  logic rst;

  full_adder_if fa_if ();

`ifdef FULL_ADDER_STATS_EN
  logic [15:0] carry_cnt;
  logic [15:0] op_cnt;
`endif

  full_adder dut (
    .clk       (clk),
    .rst       (rst),
    .fa        (fa_if)
`ifdef FULL_ADDER_STATS_EN
    ,
    .carry_cnt (carry_cnt),
    .op_cnt    (op_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] abc, input logic iv);
    fa_if.A        = abc[2];
    fa_if.B        = abc[1];
    fa_if.Cin      = abc[0];
    fa_if.in_valid = iv;
  endtask

  // advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // registered result as {out_valid, Carry_r, Sum_r}
  function automatic logic [2:0] reg_out();
    return {fa_if.out_valid, fa_if.Carry_r, fa_if.Sum_r};
  endfunction

  logic [1:0] comb_exp [8];
  logic [2:0] stream_in [3];
  logic [1:0] stream_exp [3];

  initial begin
    comb_exp   = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    stream_in  = '{3'b011, 3'b100, 3'b111};
    stream_exp = '{2'b10, 2'b01, 2'b11};

    rst = 1'b1;
    drive(3'b000, 1'b0);
    tick();
    tick();
    chk("reset_state", {29'd0, reg_out()}, 32'd0);
`ifdef FULL_ADDER_STATS_EN
    chk("reset_op_cnt", {16'd0, op_cnt}, 32'd0);
    chk("reset_carry_cnt", {16'd0, carry_cnt}, 32'd0);
`endif

    // combinational sweep while idle; registered side must stay at reset values
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), 1'b0);
      #10;
      chk($sformatf("comb_%0d", i), {30'd0, fa_if.Carry, fa_if.Sum}, {30'd0, comb_exp[i]});
      chk($sformatf("idle_hold_reset_%0d", i), {29'd0, reg_out()}, 32'd0);
    end

    // single capture of 1+1+1
    @(negedge clk);
    drive(3'b111, 1'b1);
    tick();
    chk("capture_111", {29'd0, reg_out()}, 32'b111);
    drive(3'b000, 1'b0);
    tick();
    chk("capture_hold", {29'd0, reg_out()}, 32'b011);

    // reset wins over in_valid; combinational path unaffected
    rst = 1'b1;
    drive(3'b100, 1'b1);
    tick();
    chk("rst_priority_reg", {29'd0, reg_out()}, 32'd0);
    chk("rst_priority_sum", {31'd0, fa_if.Sum}, 32'd1);
    chk("rst_priority_carry", {31'd0, fa_if.Carry}, 32'd0);

    // back-to-back stream, first beat in the cycle right after reset
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(stream_in[i], 1'b1);
      tick();
      chk($sformatf("stream_%0d", i), {29'd0, reg_out()}, {29'd0, 1'b1, stream_exp[i]});
    end

    // idle with toggling operands: hold last result, out_valid low
    for (int i = 0; i < 6; i++) begin
      drive(3'(i * 3 + 1), 1'b0);
      tick();
      chk($sformatf("idle_hold_%0d", i), {29'd0, reg_out()}, 32'b011);
    end

`ifdef FULL_ADDER_STATS_EN
    rst = 1'b1;
    drive(3'b000, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), 1'b1);
      tick();
    end
    drive(3'b000, 1'b0);
    tick();
    chk("stats_op_cnt_8", {16'd0, op_cnt}, 32'd8);
    chk("stats_carry_cnt_4", {16'd0, carry_cnt}, 32'd4);

    drive(3'b110, 1'b1);
    for (int i = 0; i < 70000; i++) tick();
    drive(3'b000, 1'b0);
    tick();
    chk("stats_carry_sat", {16'd0, carry_cnt}, 32'hFFFF);
    chk("stats_op_sat", {16'd0, op_cnt}, 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_full_adder
